// File: rtl/div_frec.sv
// Free-running clock-enable divider: square-wave clk_out of period DIV clk_in
// cycles (low L, high H) plus a one-cycle tick aligned to each clk_out rise.
module div_frec #(
    parameter int unsigned DIV = 50_000_000,
    parameter int unsigned CW  = $clog2(DIV)
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic clk_out,
    output logic tick
);

    localparam int unsigned H = DIV / 32'd2;
    localparam int unsigned L = DIV - H;

    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 32'd1);
    localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
    localparam logic [CW-1:0] RISE_AT = CW'(L);

    generate
        if (DIV < 32'd2) begin : g_bad_div
            $error("div_frec: DIV must be at least 2");
        end
        if (CW != $clog2(DIV)) begin : g_bad_cw
            $error("div_frec: CW is derived from DIV and must not be overridden");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          clk_out_q;
    logic          clk_out_d;
    logic          tick_q;
    logic          tick_d;

    // Next count, and outputs decoded from the next count so they move on the same edge.
    always_comb begin
        cnt_d     = {CW{1'b0}};
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        clk_out_d = (cnt_d >= RISE_AT);
        tick_d    = clk_out_d & ~clk_out_q;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= {CW{1'b0}};
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_div_frec.sv
// Directed bench for div_frec: DIV=2/4/5 edge tables, async reset mid-high,
// and a DIV=7 long run checking tick spacing and clk_out stability.
module tb_div_frec;

    logic clk;
    logic rst_n;
    logic clk_out2, tick2;
    logic clk_out4, tick4;
    logic clk_out5, tick5;
    logic clk_out7, tick7;

    int n_checks = 0;
    int n_fail   = 0;

    div_frec #(.DIV(2)) u_div2 (.clk_in(clk), .rst_n(rst_n), .clk_out(clk_out2), .tick(tick2));
    div_frec #(.DIV(4)) u_div4 (.clk_in(clk), .rst_n(rst_n), .clk_out(clk_out4), .tick(tick4));
    div_frec #(.DIV(5)) u_div5 (.clk_in(clk), .rst_n(rst_n), .clk_out(clk_out5), .tick(tick5));
    div_frec #(.DIV(7)) u_div7 (.clk_in(clk), .rst_n(rst_n), .clk_out(clk_out7), .tick(tick7));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected values after release edges k = 1..10 (bit k of each vector).
    logic [1:10] exp_clk2  = 10'b1010101010;
    logic [1:10] exp_tick2 = 10'b1010101010;
    logic [1:10] exp_clk4  = 10'b0110011001;
    logic [1:10] exp_tick4 = 10'b0100010001;
    logic [1:10] exp_clk5  = 10'b0011000110;
    logic [1:10] exp_tick5 = 10'b0010000100;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        logic s7;
        int   gap;
        int   n_ticks7;
        bit   seen_tick;

        rst_n = 1'b0;
        #50;
        check_eq("reset clk_out2", {31'd0, clk_out2}, 32'd0);
        check_eq("reset tick2",    {31'd0, tick2},    32'd0);
        check_eq("reset clk_out4", {31'd0, clk_out4}, 32'd0);
        check_eq("reset tick4",    {31'd0, tick4},    32'd0);
        check_eq("reset clk_out5", {31'd0, clk_out5}, 32'd0);
        check_eq("reset clk_out7", {31'd0, clk_out7}, 32'd0);
        #50;
        rst_n = 1'b1;

        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("clk_out2 k%0d", k), {31'd0, clk_out2}, {31'd0, exp_clk2[k]});
            check_eq($sformatf("tick2 k%0d", k),    {31'd0, tick2},    {31'd0, exp_tick2[k]});
            check_eq($sformatf("clk_out4 k%0d", k), {31'd0, clk_out4}, {31'd0, exp_clk4[k]});
            check_eq($sformatf("tick4 k%0d", k),    {31'd0, tick4},    {31'd0, exp_tick4[k]});
            check_eq($sformatf("clk_out5 k%0d", k), {31'd0, clk_out5}, {31'd0, exp_clk5[k]});
            check_eq($sformatf("tick5 k%0d", k),    {31'd0, tick5},    {31'd0, exp_tick5[k]});
        end

        // DIV=4 is in its first high cycle (tick high); reset between edges.
        #4;
        rst_n = 1'b0;
        #1;
        check_eq("async rst clk_out4", {31'd0, clk_out4}, 32'd0);
        check_eq("async rst tick4",    {31'd0, tick4},    32'd0);
        check_eq("async rst clk_out5", {31'd0, clk_out5}, 32'd0);
        #3;
        rst_n = 1'b1;

        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("re clk_out4 k%0d", k), {31'd0, clk_out4}, {31'd0, exp_clk4[k]});
            check_eq($sformatf("re tick4 k%0d", k),    {31'd0, tick4},    {31'd0, exp_tick4[k]});
            check_eq($sformatf("re clk_out5 k%0d", k), {31'd0, clk_out5}, {31'd0, exp_clk5[k]});
            check_eq($sformatf("re tick5 k%0d", k),    {31'd0, tick5},    {31'd0, exp_tick5[k]});
        end

        // DIV=7 long run: ticks exactly 7 apart, clk_out high for 3 cycles after each tick.
        gap       = 0;
        n_ticks7  = 0;
        seen_tick = 1'b0;
        for (int k = 6; k <= 7010; k++) begin
            @(posedge clk);
            #1;
            s7 = clk_out7;
            if (tick7) begin
                if (seen_tick) begin
                    check_eq("div7 tick gap", gap, 32'd7);
                end else begin
                    check_eq("div7 first tick edge", k, 32'd11);
                end
                seen_tick = 1'b1;
                gap = 1;
                n_ticks7++;
            end else begin
                gap++;
            end
            if (seen_tick) begin
                check_eq("div7 clk_out phase", {31'd0, s7}, (gap <= 3) ? 32'd1 : 32'd0);
            end else begin
                check_eq("div7 tick timeout", {31'd0, (gap > 14) ? 1'b1 : 1'b0}, 32'd0);
            end
            @(negedge clk);
            check_eq("div7 clk_out stable", {31'd0, clk_out7}, {31'd0, s7});
        end
        check_eq("div7 tick count", n_ticks7, 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
